// File: rtl/rpn_alu_sequencer.sv
// Reverse-Polish token sequencer: keeps an operand stack and drives a shared int/float arithmetic unit.
// Optional build macro RPN_HI_PUSH_EN: integer mul/div also pushes alu_outh beneath alu_out.
module rpn_alu_sequencer #(
  parameter int N       = 32,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tok_valid,
  output logic                       tok_ready,
  input  logic [1:0]                 tok_cmd,
  input  logic [N-1:0]               tok_data,
  input  logic [1:0]                 tok_s,
  input  logic                       tok_float,
  output logic [N-1:0]               alu_a,
  output logic [N-1:0]               alu_b,
  output logic [1:0]                 alu_s,
  output logic                       alu_float,
  input  logic [N-1:0]               alu_out,
  input  logic [N-1:0]               alu_outh,
  input  logic                       alu_car,
  output logic [N-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       car_flag,
  output logic [N-1:0]               hi_word,
  output logic                       err,
  input  logic                       err_clr
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);
  localparam logic [CW-1:0] LAT  = CW'(ALU_LAT);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {
    CMD_PUSH  = 2'b00,
    CMD_OP    = 2'b01,
    CMD_POP   = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_depth, w_depth_nxt;
  logic [N-1:0]  r_stack [DEPTH];
  logic [N-1:0]  r_alu_a, r_alu_b, r_hi;
  logic [1:0]    r_alu_s;
  logic          r_alu_float, r_car, r_err;

  logic          w_accept, w_push, w_err_set, w_load_ops, w_sample;
  logic          w_int_addsub, w_int_muldiv;
  logic [N-1:0]  w_push_data;
  logic [AW-1:0] w_push_addr, w_top_idx, w_second_idx;
`ifdef RPN_HI_PUSH_EN
  logic          r_hi_pend, w_hi_pend_set;
  logic [N-1:0]  r_lo_hold;
`endif

  assign w_accept     = tok_valid && (r_state == IDLE);
  assign w_int_addsub = !r_alu_float && !r_alu_s[1];
  assign w_int_muldiv = !r_alu_float && r_alu_s[1];
  assign w_push_addr  = AW'(r_depth);
  assign w_top_idx    = AW'(r_depth - ONE);
  assign w_second_idx = AW'(r_depth - TWO);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_push_data = alu_out;
    w_err_set   = 1'b0;
    w_load_ops  = 1'b0;
    w_sample    = 1'b0;
`ifdef RPN_HI_PUSH_EN
    w_hi_pend_set = 1'b0;
`endif
    unique case (r_state)
      IDLE: if (w_accept) begin
        unique case (cmd_t'(tok_cmd))
          CMD_PUSH: begin
            if (r_depth == FULL) w_err_set = 1'b1;
            else begin
              w_push      = 1'b1;
              w_push_data = tok_data;
            end
          end
          CMD_POP: begin
            if (r_depth == '0) w_err_set = 1'b1;
            else               w_depth_nxt = r_depth - ONE;
          end
          CMD_CLEAR: w_depth_nxt = '0;
          CMD_OP: begin
            if (r_depth < TWO) w_err_set = 1'b1;
            else begin
              w_load_ops  = 1'b1;
              w_depth_nxt = r_depth - TWO;
              w_state_nxt = EXEC;
            end
          end
        endcase
      end
      EXEC: begin
`ifdef RPN_HI_PUSH_EN
        // Second half of a mul/div result: the low word held from the sampling cycle.
        if (r_hi_pend) begin
          w_push      = 1'b1;
          w_push_data = r_lo_hold;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_sample = 1'b1;
          w_push   = 1'b1;
          if (w_int_muldiv) begin
            w_push_data   = alu_outh;
            w_hi_pend_set = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
`else
        if (r_cnt == CW'(1)) begin
          w_sample    = 1'b1;
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      end
    endcase
    if (w_push) w_depth_nxt = r_depth + ONE;
  end

  // NOTE: stack storage carries no reset; depth alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_addr] <= w_push_data;
  end

  // NOTE: state registers use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_depth     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_alu_float <= 1'b0;
      r_car       <= 1'b0;
      r_hi        <= '0;
      r_err       <= 1'b0;
`ifdef RPN_HI_PUSH_EN
      r_hi_pend   <= 1'b0;
      r_lo_hold   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      if (w_load_ops) begin
        r_cnt       <= LAT;
        r_alu_a     <= r_stack[w_second_idx];
        r_alu_b     <= r_stack[w_top_idx];
        r_alu_s     <= tok_s;
        r_alu_float <= tok_float;
      end else if (r_state == EXEC && r_cnt != CW'(1)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_sample && w_int_addsub) r_car <= alu_car;
      if (w_sample && w_int_muldiv) r_hi  <= alu_outh;
      // A same-cycle error wins over the clear request.
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
`ifdef RPN_HI_PUSH_EN
      r_hi_pend <= w_hi_pend_set;
      if (w_hi_pend_set) r_lo_hold <= alu_out;
`endif
    end
  end

  assign tok_ready = (r_state == IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign alu_float = r_alu_float;
  assign top       = (r_depth == '0) ? '0 : r_stack[w_top_idx];
  assign depth     = r_depth;
  assign car_flag  = r_car;
  assign hi_word   = r_hi;
  assign err       = r_err;

endmodule

// File: tb/tb_rpn_alu_sequencer.sv
// Randomised and directed bench for rpn_alu_sequencer against a queue-based stack model;
// two instances (ALU_LAT=1 and ALU_LAT=3) share one token stream.
module tb_rpn_alu_sequencer;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [N-1:0] out;
    logic [N-1:0] outh;
    logic         car;
  } alu_res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0, tok_float = 1'b0, err_clr = 1'b0;
  logic [1:0]    tok_cmd = '0, tok_s = '0;
  logic [N-1:0]  tok_data = '0;

  logic          rdy1, f1, car1, err1, rdy3, f3, car3, err3;
  logic [1:0]    s1, s3;
  logic [N-1:0]  a1, b1, top1, hi1, a3, b3, top3, hi3;
  logic [DW-1:0] depth1, depth3;
  alu_res_t      res1, res3;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] m_stack [$];
  logic         m_err, m_car;
  logic [N-1:0] m_hi;

  // Single-precision helpers for the behavioural float unit (normal numbers only).
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]);
    for (int i = 0; i < 256; i++) begin
      if (e > 127)      begin r = r * 2.0; e--; end
      else if (e < 127) begin r = r / 2.0; e++; end
    end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real         r;
    int          e;
    logic        sgn;
    logic [22:0] m;
    if (v == 0.0) return 32'd0;
    sgn = (v < 0.0);
    r   = sgn ? -v : v;
    e   = 127;
    for (int i = 0; i < 300; i++) begin
      if (r >= 2.0)     begin r = r / 2.0; e++; end
      else if (r < 1.0) begin r = r * 2.0; e--; end
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0)   return {sgn, 31'd0};
    m = 23'($rtoi((r - 1.0) * 8388608.0));
    return {sgn, 8'(e), m};
  endfunction

  function automatic alu_res_t alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic [1:0] s, input logic f);
    alu_res_t       r;
    logic [N:0]     w;
    logic [2*N-1:0] p;
    real            x, y;
    r = '0;
    if (f) begin
      x = f2r(a);
      y = f2r(b);
      case (s)
        2'b00:   r.out = r2f(x + y);
        2'b01:   r.out = r2f(x - y);
        2'b10:   r.out = r2f(x * y);
        default: r.out = (y == 0.0) ? '1 : r2f(x / y);
      endcase
    end else begin
      case (s)
        2'b00: begin w = {1'b0, a} + {1'b0, b}; r.out = w[N-1:0]; r.car = w[N]; end
        2'b01: begin w = {1'b0, a} + {1'b0, ~b} + (N+1)'(1); r.out = w[N-1:0]; r.car = w[N]; end
        2'b10: begin p = (2*N)'(a) * (2*N)'(b); r.out = p[N-1:0]; r.outh = p[2*N-1:N]; end
        default: begin
          if (b == '0) begin r.out = '1; r.outh = a; end
          else begin r.out = a / b; r.outh = a % b; end
        end
      endcase
    end
    return r;
  endfunction

  assign res1 = alu_fn(a1, b1, s1, f1);
  assign res3 = alu_fn(a3, b3, s3, f3);

  rpn_alu_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(rdy1), .tok_cmd(tok_cmd),
    .tok_data(tok_data), .tok_s(tok_s), .tok_float(tok_float),
    .alu_a(a1), .alu_b(b1), .alu_s(s1), .alu_float(f1),
    .alu_out(res1.out), .alu_outh(res1.outh), .alu_car(res1.car),
    .top(top1), .depth(depth1), .car_flag(car1), .hi_word(hi1), .err(err1), .err_clr(err_clr)
  );

  rpn_alu_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(rdy3), .tok_cmd(tok_cmd),
    .tok_data(tok_data), .tok_s(tok_s), .tok_float(tok_float),
    .alu_a(a3), .alu_b(b3), .alu_s(s3), .alu_float(f3),
    .alu_out(res3.out), .alu_outh(res3.outh), .alu_car(res3.car),
    .top(top3), .depth(depth3), .car_flag(car3), .hi_word(hi3), .err(err3), .err_clr(err_clr)
  );

  function automatic logic [N-1:0] m_top();
    return (m_stack.size() == 0) ? '0 : m_stack[$];
  endfunction

  task automatic model_token(input logic [1:0] cmd, input logic [N-1:0] data,
                             input logic [1:0] s, input logic f, input logic clr);
    logic         set;
    logic [N-1:0] a, b;
    alu_res_t     r;
    set = 1'b0;
    case (cmd)
      2'b00: if (m_stack.size() == DEPTH) set = 1'b1; else m_stack.push_back(data);
      2'b10: if (m_stack.size() == 0) set = 1'b1; else void'(m_stack.pop_back());
      2'b11: m_stack.delete();
      default: begin
        if (m_stack.size() < 2) set = 1'b1;
        else begin
          b = m_stack.pop_back();
          a = m_stack.pop_back();
          r = alu_fn(a, b, s, f);
          if (!f && !s[1]) m_car = r.car;
          if (!f && s[1])  m_hi  = r.outh;
`ifdef RPN_HI_PUSH_EN
          if (!f && s[1]) m_stack.push_back(r.outh);
`endif
          m_stack.push_back(r.out);
        end
      end
    endcase
    if (set)      m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [1:0] cmd, input logic [N-1:0] data,
                      input logic [1:0] s, input logic f, input logic clr);
    int n = 0;
    tok_cmd = cmd; tok_data = data; tok_s = s; tok_float = f; err_clr = clr;
    tok_valid = 1'b1;
    while (!(rdy1 && rdy3) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      bad++; total++;
      $display("FAIL send_timeout: ready=%b%b required 11", rdy1, rdy3);
    end
    @(posedge clk);
    model_token(cmd, data, s, f, clr);
    @(negedge clk);
    tok_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy1 && rdy3) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      bad++; total++;
      $display("FAIL idle_timeout: ready=%b%b required 11", rdy1, rdy3);
    end
  endtask

  task automatic do_reset();
    tok_valid = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_stack.delete();
    m_err = 1'b0; m_car = 1'b0; m_hi = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({top1, depth1, err1, car1, hi1, a1, b1, s1, f1} !== '0) begin
      bad++; $display("FAIL reset_outputs: top=%h depth=%0d err=%b car=%b hi=%h a=%h b=%h required all 0",
                      top1, depth1, err1, car1, hi1, a1, b1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rdy1, rdy3} !== 2'b11) begin
      bad++; $display("FAIL reset_ready: got %b%b want 11", rdy1, rdy3);
    end
    total++;
    if ({depth3, top3, err3} !== '0) begin
      bad++; $display("FAIL reset_lat3: depth=%0d top=%h err=%b want 0", depth3, top3, err3);
    end
    m_stack.delete();
    m_err = 1'b0; m_car = 1'b0; m_hi = '0;
  endtask

  task automatic test_add_timing();
    logic [4:0] v1, v3;
    logic [N-1:0] top3_before;
    logic [DW-1:0] depth1_k1;
    do_reset();
    send(2'b00, 32'd3, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd4, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b00, 1'b0, 1'b0);
    top3_before = '1;
    depth1_k1   = depth1;
    for (int i = 0; i < 5; i++) begin
      v1[i] = rdy1;
      v3[i] = rdy3;
      if (i == 1) begin
        total++;
        if (top1 !== 32'd7) begin bad++; $display("FAIL add_top_k2: got %h want %h", top1, 32'd7); end
      end
      if (i == 2) top3_before = top3;
      if (i == 3) begin
        total++;
        if (top3 !== 32'd7) begin bad++; $display("FAIL add_top_lat3: got %h want %h", top3, 32'd7); end
      end
      @(negedge clk);
    end
    total++;
    if (v1 !== 5'b11110) begin bad++; $display("FAIL add_ready_lat1: got %b want 11110", v1); end
    total++;
    if (v3 !== 5'b11000) begin bad++; $display("FAIL add_ready_lat3: got %b want 11000", v3); end
    total++;
    if (depth1_k1 !== DW'(0) || top3_before !== '0) begin
      bad++; $display("FAIL add_popped: depth=%0d top3=%h want 0 0", depth1_k1, top3_before);
    end
    total++;
    if (depth1 !== DW'(1) || car1 !== 1'b0) begin
      bad++; $display("FAIL add_final: depth=%0d car=%b want 1 0", depth1, car1);
    end
  endtask

  task automatic test_sub();
    do_reset();
    send(2'b00, 32'd5, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd7, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b01, 1'b0, 1'b0);
    wait_idle();
    total++;
    if (top1 !== 32'hFFFF_FFFE || car1 !== 1'b0) begin
      bad++; $display("FAIL sub_borrow: top=%h car=%b want fffffffe 0", top1, car1);
    end
    send(2'b11, '0, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd7, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd5, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b01, 1'b0, 1'b0);
    wait_idle();
    total++;
    if (top1 !== 32'd2 || car1 !== 1'b1 || depth1 !== DW'(1)) begin
      bad++; $display("FAIL sub_carry: top=%h car=%b depth=%0d want 2 1 1", top1, car1, depth1);
    end
  endtask

  // Runs after test_sub so car_flag is 1 and must survive a float op.
  task automatic test_float();
    send(2'b11, '0, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'h3FC0_0000, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'h4000_0000, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b00, 1'b1, 1'b0);
    wait_idle();
    total++;
    if (top1 !== 32'h4060_0000 || depth1 !== DW'(1)) begin
      bad++; $display("FAIL float_add: top=%h depth=%0d want 40600000 1", top1, depth1);
    end
    total++;
    if (car1 !== 1'b1) begin bad++; $display("FAIL float_car_hold: got %b want 1", car1); end
  endtask

  task automatic test_errors();
    logic [N-1:0] vals [8];
    do_reset();
    send(2'b00, 32'd9, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b00, 1'b0, 1'b0);
    total++;
    if (err1 !== 1'b1 || depth1 !== DW'(1) || top1 !== 32'd9 || rdy1 !== 1'b1) begin
      bad++; $display("FAIL op_underflow: err=%b depth=%0d top=%h rdy=%b want 1 1 9 1",
                      err1, depth1, top1, rdy1);
    end
    err_clr = 1'b1;
    @(posedge clk);
    m_err = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err1 !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err1); end
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      send(2'b00, vals[i], 2'b00, 1'b0, 1'b0);
    end
    total++;
    if (err1 !== 1'b1 || depth1 !== DW'(DEPTH) || top1 !== vals[6]) begin
      bad++; $display("FAIL push_overflow: err=%b depth=%0d top=%h want 1 8 %h", err1, depth1, top1, vals[6]);
    end
    send(2'b00, 32'h1234, 2'b00, 1'b0, 1'b1);
    total++;
    if (err1 !== 1'b1 || top1 !== vals[6]) begin
      bad++; $display("FAIL err_set_beats_clr: err=%b top=%h want 1 %h", err1, top1, vals[6]);
    end
    send(2'b11, '0, 2'b00, 1'b0, 1'b1);
    total++;
    if (err1 !== 1'b0 || depth1 !== DW'(0) || top1 !== '0) begin
      bad++; $display("FAIL clear_with_clr: err=%b depth=%0d top=%h want 0 0 0", err1, depth1, top1);
    end
    send(2'b10, '0, 2'b00, 1'b0, 1'b0);
    total++;
    if (err1 !== 1'b1 || depth1 !== DW'(0)) begin
      bad++; $display("FAIL pop_underflow: err=%b depth=%0d want 1 0", err1, depth1);
    end
    send(2'b00, 32'd1, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd2, 2'b00, 1'b0, 1'b0);
    send(2'b10, '0, 2'b00, 1'b0, 1'b0);
    total++;
    if (top1 !== 32'd1 || depth1 !== DW'(1)) begin
      bad++; $display("FAIL pop_ok: top=%h depth=%0d want 1 1", top1, depth1);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    send(2'b00, 32'h0001_0000, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'h0001_0000, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b10, 1'b0, 1'b0);
    wait_idle();
    total++;
    if (top1 !== '0 || hi1 !== 32'd1) begin
      bad++; $display("FAIL mul_result: top=%h hi=%h want 0 1", top1, hi1);
    end
`ifdef RPN_HI_PUSH_EN
    total++;
    if (depth1 !== DW'(2)) begin bad++; $display("FAIL mul_depth: got %0d want 2", depth1); end
    send(2'b10, '0, 2'b00, 1'b0, 1'b0);
    total++;
    if (top1 !== 32'd1) begin bad++; $display("FAIL mul_second: got %h want 1", top1); end
`else
    total++;
    if (depth1 !== DW'(1)) begin bad++; $display("FAIL mul_depth: got %0d want 1", depth1); end
`endif
    send(2'b11, '0, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd100, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd7, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b11, 1'b0, 1'b0);
    wait_idle();
    total++;
    if (top1 !== 32'd14 || hi1 !== 32'd2 || top3 !== 32'd14 || hi3 !== 32'd2) begin
      bad++; $display("FAIL div_result: top=%h hi=%h top3=%h hi3=%h want e 2", top1, hi1, top3, hi3);
    end
  endtask

  task automatic test_random();
    int           r;
    logic [1:0]   cmd;
    do_reset();
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       cmd = 2'b00;
      else if (r < 15) cmd = 2'b01;
      else if (r < 18) cmd = 2'b10;
      else             cmd = 2'b11;
      send(cmd, $urandom, 2'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
      wait_idle();
      total++;
      if (top1 !== m_top() || depth1 !== DW'(m_stack.size()) || err1 !== m_err ||
          car1 !== m_car || hi1 !== m_hi) begin
        bad++;
        $display("FAIL random_%0d: top=%h depth=%0d err=%b car=%b hi=%h want %h %0d %b %b %h",
                 t, top1, depth1, err1, car1, hi1, m_top(), m_stack.size(), m_err, m_car, m_hi);
      end
      total++;
      if (top3 !== m_top() || depth3 !== DW'(m_stack.size())) begin
        bad++; $display("FAIL random_lat3_%0d: top=%h depth=%0d want %h %0d",
                        t, top3, depth3, m_top(), m_stack.size());
      end
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    send(2'b00, 32'd5, 2'b00, 1'b0, 1'b0);
    send(2'b00, 32'd6, 2'b00, 1'b0, 1'b0);
    send(2'b01, '0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (rdy3 !== 1'b0) begin bad++; $display("FAIL exec_busy: rdy3=%b want 0", rdy3); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_stack.delete();
    m_err = 1'b0; m_car = 1'b0; m_hi = '0;
    total++;
    if (rdy3 !== 1'b1 || depth3 !== DW'(0) || top3 !== '0 || err3 !== 1'b0) begin
      bad++; $display("FAIL exec_reset: rdy=%b depth=%0d top=%h err=%b want 1 0 0 0",
                      rdy3, depth3, top3, err3);
    end
    send(2'b00, 32'd1, 2'b00, 1'b0, 1'b0);
    total++;
    if (top3 !== 32'd1 || depth3 !== DW'(1)) begin
      bad++; $display("FAIL exec_reset_push: top=%h depth=%0d want 1 1", top3, depth3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_err = 1'b0; m_car = 1'b0; m_hi = '0;
    test_reset();
    test_add_timing();
    test_sub();
    test_float();
    test_errors();
    test_muldiv();
    test_random();
    test_reset_in_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
